booth_seq_divider: RTL and testbench

//  Sequential signed divider, the inverse companion of the combinational Booth multiplier.

---
 rtl/booth_seq_divider_pkg.sv | 27 ++
 rtl/booth_seq_divider_signed_magnitude.sv | 23 ++
 rtl/booth_seq_divider.sv | 142 ++++++++++++++
 tb/tb_booth_seq_divider.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/booth_seq_divider_pkg.sv
// ============================================================================
//  Module      : booth_seq_divider_pkg
//  Description : Shared definitions for the sequential signed divider:
//                FSM state encodings and a counter-width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package booth_seq_divider_pkg;

  // Divider FSM states (2-bit encoding)
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Number of bits needed to hold values 0 .. value-1
  function automatic int clog2(input int value);
    int width;
    width = 0;
    while ((1 << width) < value) width = width + 1;
    return width;
  endfunction

endpackage

`default_nettype wire

// File: rtl/booth_seq_divider_signed_magnitude.sv
// ============================================================================
//  Module      : booth_seq_divider_signed_magnitude
//  Description : Conditional two's-complement negate. With negate tied to the
//                value's sign bit it yields the unsigned magnitude; with
//                negate tied to a result sign it restores the signed value.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module booth_seq_divider_signed_magnitude #(
  parameter int N = 4
) (
  input  logic [N-1:0] value,
  input  logic         negate,
  output logic [N-1:0] result
);

  // -(-2^(N-1)) wraps to 2^(N-1), which reads correctly as an unsigned magnitude
  assign result = negate ? -value : value;

endmodule

`default_nettype wire

// File: rtl/booth_seq_divider.sv
// ============================================================================
//  Module      : booth_seq_divider
//  Description : Sequential signed restoring divider, one quotient bit per
//                clock. Truncates toward zero; remainder follows the dividend
//                sign. Fixed latency of N+1 clocks from acceptance to done.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module booth_seq_divider
  import booth_seq_divider_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero,
  output logic         overflow
);

  localparam int           CW      = clog2(N + 1);
  localparam logic [N-1:0] MIN_VAL = {1'b1, {(N-1){1'b0}}};

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  // The partial remainder always stays below the divisor magnitude (< 2^N),
  // so N bits are stored; the (N+1)-bit value is the shifted trial below.
  logic [N-1:0]  rem;
  logic [N-1:0]  qsh;
  logic [N-1:0]  mag_dv;
  logic          neg_dd;
  logic          neg_dv;
  logic          dz_pend;
  logic          ov_pend;

  logic [N-1:0]  mag_dd_w;
  logic [N-1:0]  mag_dv_w;
  logic [N-1:0]  q_fix;
  logic [N-1:0]  r_fix;
  logic [N:0]    trial;
  logic [N+1:0]  diff;
  logic          step_neg;

  // Operand split into unsigned magnitudes
  booth_seq_divider_signed_magnitude #(.N(N)) u_mag_dd (
    .value  (dividend),
    .negate (dividend[N-1]),
    .result (mag_dd_w)
  );

  booth_seq_divider_signed_magnitude #(.N(N)) u_mag_dv (
    .value  (divisor),
    .negate (divisor[N-1]),
    .result (mag_dv_w)
  );

  // Result sign correction
  booth_seq_divider_signed_magnitude #(.N(N)) u_fix_q (
    .value  (qsh),
    .negate (neg_dd ^ neg_dv),
    .result (q_fix)
  );

  booth_seq_divider_signed_magnitude #(.N(N)) u_fix_r (
    .value  (rem),
    .negate (neg_dd),
    .result (r_fix)
  );

  // Restoring step: shift next dividend bit in, trial-subtract the divisor
  assign trial    = {rem, qsh[N-1]};
  assign diff     = {1'b0, trial} - {2'b00, mag_dv};
  assign step_neg = diff[N+1];

  assign busy = (state == S_CALC) || (state == S_FIX);

  // FSM, iteration datapath and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      rem         <= '0;
      qsh         <= '0;
      mag_dv      <= '0;
      neg_dd      <= 1'b0;
      neg_dv      <= 1'b0;
      dz_pend     <= 1'b0;
      ov_pend     <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            cnt     <= '0;
            rem     <= '0;
            qsh     <= mag_dd_w;
            mag_dv  <= mag_dv_w;
            neg_dd  <= dividend[N-1];
            neg_dv  <= divisor[N-1];
            dz_pend <= (divisor == '0);
            ov_pend <= (dividend == MIN_VAL) && (divisor == '1);
            state   <= S_CALC;
          end else begin
            state <= S_IDLE;
          end
        end
        S_CALC: begin
          rem <= step_neg ? trial[N-1:0] : diff[N-1:0];
          qsh <= {qsh[N-2:0], ~step_neg};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(N - 1)) state <= S_FIX;
        end
        S_FIX: begin
          // With a zero divisor every step succeeds, so the partial remainder
          // already equals |dividend|; only the quotient needs overriding.
          quotient    <= dz_pend ? '1 : q_fix;
          remainder   <= r_fix;
          div_by_zero <= dz_pend;
          overflow    <= ov_pend;
          done        <= 1'b1;
          state       <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_booth_seq_divider.sv
// ============================================================================
//  Module      : tb_booth_seq_divider
//  Description : Self-checking bench for booth_seq_divider (N=4).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_booth_seq_divider;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;
  logic       overflow;

  int n_asserts;
  int n_fail;

  booth_seq_divider #(.N(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  // 10-unit clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called #1 after an edge; returns edges until done and busy samples seen
  task automatic wait_done(output int n, output int nbusy);
    n = 0;
    nbusy = 0;
    forever begin
      @(posedge clk);
      #1;
      n++;
      if (done) break;
      nbusy += busy;
      if (n >= 20) begin
        chk("done_timeout", 32'(n), 32'd0);
        break;
      end
    end
  endtask

  // Issue one division after 'gap' idle cycles and check against the model
  task automatic run_div(input int a, input int b, input int gap);
    int n, nb, b0, eq, er;
    logic edz, eov;
    edz = (b == 0);
    eov = (a == -8) && (b == -1);
    if (edz) begin
      eq = -1; er = a;
    end else if (eov) begin
      eq = -8; er = 0;
    end else begin
      eq = a / b; er = a % b;
    end
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    start    = 1'b1;
    dividend = 4'(a);
    divisor  = 4'(b);
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 4'($urandom);
    divisor  = 4'($urandom);
    b0 = 32'(busy);
    wait_done(n, nb);
    chk("latency", 32'(n), 32'd5);
    chk("busy_cycles", 32'(b0 + nb), 32'd5);
    chk("quotient", 32'(quotient), eq & 32'hF);
    chk("remainder", 32'(remainder), er & 32'hF);
    chk("div_by_zero", 32'(div_by_zero), 32'(edz));
    chk("overflow", 32'(overflow), 32'(eov));
  endtask

  initial begin
    int n, nb, dones;
    n_asserts = 0;
    n_fail    = 0;
    clk       = 1'b0;
    rst       = 1'b1;
    start     = 1'b0;
    dividend  = '0;
    divisor   = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_quotient", 32'(quotient), 32'd0);
    chk("rst_remainder", 32'(remainder), 32'd0);
    chk("rst_flags", {30'd0, div_by_zero, overflow}, 32'd0);
    rst = 1'b0;

    // Directed sign combinations and exceptions
    run_div(7, 2, 0);
    chk("q_7_2", 32'(quotient), 32'h3);
    run_div(-7, 2, 1);
    chk("q_m7_2", 32'(quotient), 32'hD);
    chk("r_m7_2", 32'(remainder), 32'hF);
    run_div(7, -2, 0);
    run_div(-7, -2, 2);
    run_div(-8, -1, 0);
    chk("q_ovf", 32'(quotient), 32'h8);
    run_div(-8, 1, 0);
    run_div(5, 0, 1);
    chk("q_dz", 32'(quotient), 32'hF);

    // Start pulses during CALC are ignored and not queued
    run_div(7, 2, 1);
    @(posedge clk);
    #1;
    start = 1'b1; dividend = 4'd6; divisor = 4'd3;
    @(posedge clk);
    #1;
    start = 1'b1; dividend = 4'd1; divisor = 4'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(n, nb);
    chk("ign_latency", 32'(n + 1), 32'd5);
    chk("ign_quotient", 32'(quotient), 32'h2);
    chk("ign_remainder", 32'(remainder), 32'h0);
    dones = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      dones += done + busy;
    end
    chk("no_queue", 32'(dones), 32'd0);
    chk("hold_quotient", 32'(quotient), 32'h2);

    // Back-to-back: start in the DONE cycle
    run_div(7, 2, 0);
    run_div(6, 3, 0);

    // Asynchronous reset mid-CALC
    run_div(5, 0, 0);
    start = 1'b1; dividend = 4'd7; divisor = 4'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_quotient", 32'(quotient), 32'd0);
    chk("arst_remainder", 32'(remainder), 32'd0);
    chk("arst_flags", {30'd0, div_by_zero, overflow}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_div(6, 3, 1);

    // Exhaustive sweep of all operand pairs
    for (int a = -8; a < 8; a++) begin
      for (int b = -8; b < 8; b++) begin
        run_div(a, b, 0);
      end
    end

    // Random operands with random idle gaps
    for (int i = 0; i < 40; i++) begin
      run_div(int'($urandom_range(0, 15)) - 8, int'($urandom_range(0, 15)) - 8,
              int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
